// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control stage: funct3 codes,
// one-hot memory size masks and the controller state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  localparam logic [3:0] MASK_D = 4'b0001;
  localparam logic [3:0] MASK_W = 4'b0010;
  localparam logic [3:0] MASK_H = 4'b0100;
  localparam logic [3:0] MASK_B = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: store data shift, load right-shift with
// sign/zero extension, and the misalignment/illegal-op check on incoming ops.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  chk_funct3,
  input  logic        chk_store,
  input  logic [2:0]  chk_addr_lo,
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext,
  output logic        misalign
);

  function automatic logic [63:0] load_extend(input logic [63:0] v, input logic [2:0] f3);
    logic sx;
    sx = ~f3[2];
    case (f3[1:0])
      2'b00:   return {{56{sx & v[7]}},  v[7:0]};
      2'b01:   return {{48{sx & v[15]}}, v[15:0]};
      2'b10:   return {{32{sx & v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  logic [63:0] rdata_sh;

  assign wdata_sh  = wdata << {addr_lo, 3'b000};
  assign rdata_sh  = rdata >> {addr_lo, 3'b000};
  assign rdata_ext = load_extend(rdata_sh, funct3);

  // Unsigned store variants and funct3=111 never reach memory
  always_comb begin
    misalign = 1'b0;
    if (chk_funct3 == F3_ILL || (chk_store && chk_funct3[2])) begin
      misalign = 1'b1;
    end else begin
      case (chk_funct3[1:0])
        2'b01:   misalign = chk_addr_lo[0];
        2'b10:   misalign = |chk_addr_lo[1:0];
        2'b11:   misalign = |chk_addr_lo;
        default: misalign = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage between EXU and WBU: one op at a time, a single
// memory access cycle, and a held result until WBU accepts it.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_store,
  input  logic [2:0]       in_funct3,
  input  logic [63:0]      in_addr,
  input  logic [63:0]      in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mem_ena,
  output logic             mem_wen,
  output logic [3:0]       mem_mask,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  input  logic [63:0]      mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_rdata,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_store,
  output logic             out_misalign
);

  state_e      state, state_nx;
  logic [63:0] addr_q, wdata_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [TAG_W-1:0] tag_q;
  logic [63:0] wdata_sh, rdata_ext;
  logic        misalign;

  lsu_align u_align (
    .chk_funct3 (in_funct3),
    .chk_store  (in_store),
    .chk_addr_lo(in_addr[2:0]),
    .funct3     (funct3_q),
    .addr_lo    (addr_q[2:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wdata_sh   (wdata_sh),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Memory strobes decode from state so an async reset kills them at once
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_ena   = 1'b0;
    mem_wen   = 1'b0;
    mem_mask  = 4'b0000;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = misalign ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_ena = 1'b1;
        mem_wen = store_q;
        case (funct3_q[1:0])
          2'b00:   mem_mask = MASK_B;
          2'b01:   mem_mask = MASK_H;
          2'b10:   mem_mask = MASK_W;
          default: mem_mask = MASK_D;
        endcase
        state_nx = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      store_q      <= 1'b0;
      tag_q        <= '0;
      out_rdata    <= '0;
      out_misalign <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      addr_q       <= in_addr;
      wdata_q      <= in_wdata;
      funct3_q     <= in_funct3;
      store_q      <= in_store;
      tag_q        <= in_tag;
      out_rdata    <= '0;
      out_misalign <= misalign;
    end else if (state == ACCESS) begin
      out_rdata    <= store_q ? 64'd0 : rdata_ext;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_sh;
  assign out_tag   = tag_q;
  assign out_store = store_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array memory environment plus a byte-level
// reference model of RV64 loads/stores, directed cases then random ops.
module tb_lsu_ctrl;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_store;
  logic [2:0]       in_funct3;
  logic [63:0]      in_addr, in_wdata;
  logic [TAG_W-1:0] in_tag;
  logic             mem_ena, mem_wen;
  logic [3:0]       mem_mask;
  logic [63:0]      mem_addr, mem_wdata, mem_rdata;
  logic             out_valid, out_ready;
  logic [63:0]      out_rdata;
  logic [TAG_W-1:0] out_tag;
  logic             out_store, out_misalign;

  int errors = 0;
  int checks = 0;

  logic [7:0] env_mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int env_sz;

  lsu_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_tag(out_tag), .out_store(out_store), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  // Memory environment: lane-masked, unshifted, combinational read
  always_comb begin
    env_sz = 0;
    case (mem_mask)
      4'b0001: env_sz = 8;
      4'b0010: env_sz = 4;
      4'b0100: env_sz = 2;
      4'b1000: env_sz = 1;
      default: env_sz = 0;
    endcase
    mem_rdata = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(mem_addr[2:0]) && i < int'(mem_addr[2:0]) + env_sz)
        mem_rdata[8*i +: 8] = env_mem[{mem_addr[7:3], 3'(i)}];
  end

  always @(posedge clk)
    if (mem_ena && mem_wen)
      for (int i = 0; i < 8; i++)
        if (i >= int'(mem_addr[2:0]) && i < int'(mem_addr[2:0]) + env_sz)
          env_mem[{mem_addr[7:3], 3'(i)}] <= mem_wdata[8*i +: 8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: size/sign rules applied byte by byte to a flat memory
  function automatic void model(input logic st, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] wd, output logic mis, output logic [63:0] rd);
    int sz;
    logic [63:0] val;
    sz  = 1 << f3[1:0];
    mis = (f3 == 3'd7) || (st && f3[2]) || ((a % 64'(sz)) != 0);
    rd  = '0;
    val = '0;
    if (!mis) begin
      if (st) begin
        for (int i = 0; i < sz; i++) ref_mem[int'(a[7:0]) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) val = val | (64'(ref_mem[int'(a[7:0]) + i]) << (8*i));
        if (!f3[2] && val[8*sz-1] && sz < 8) val = val | ({64{1'b1}} << (8*sz));
        rd = val;
      end
    end
  endfunction

  function automatic logic [3:0] exp_mask(input int sz);
    case (sz)
      1:       return 4'b1000;
      2:       return 4'b0100;
      4:       return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [TAG_W-1:0] tg, input int stall,
                       output logic [63:0] got, output logic [63:0] wd_seen);
    logic exp_mis;
    logic [63:0] exp_rd;
    int cyc, ena_n;
    model(st, f3, a, wd, exp_mis, exp_rd);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd; in_tag = tg;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_addr = {$urandom(), $urandom()}; in_wdata = {$urandom(), $urandom()};
    cyc = 1; ena_n = 0; wd_seen = '0;
    while (!out_valid && cyc < 6) begin
      if (mem_ena) begin
        ena_n++;
        wd_seen = mem_wdata;
        chk("mem_wen", 64'(mem_wen), 64'(st));
        chk("mem_mask", 64'(mem_mask), 64'(exp_mask(1 << f3[1:0])));
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, wd << (8 * int'(a[2:0])));
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), exp_mis ? 64'd1 : 64'd2);
    chk("ena_cycles", 64'(ena_n), exp_mis ? 64'd0 : 64'd1);
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("out_misalign", 64'(out_misalign), 64'(exp_mis));
    chk("out_rdata", out_rdata, exp_rd);
    chk("out_tag", 64'(out_tag), 64'(tg));
    chk("out_store", 64'(out_store), 64'(st));
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    got = out_rdata;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_rdata", out_rdata, exp_rd);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_mem_ena", 64'(mem_ena), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("ret_valid", 64'(out_valid), 64'd0);
    chk("ret_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] got, wds, a;
    logic st;
    logic [2:0] f3;
    logic exp_mis_d;
    logic [63:0] exp_rd_d;
    rst = 1'b1; in_valid = 1'b0; in_store = 1'b0; in_funct3 = '0; in_addr = '0;
    in_wdata = '0; in_tag = '0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_rdata", out_rdata, 64'd0);
    chk("rst_mem_ena", 64'(mem_ena), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_op(1'b1, 3'b011, 64'h80000008, 64'h1122334455667788, 5'd1, 0, got, wds);
    chk("sd_wdata", wds, 64'h1122334455667788);
    chk("sd_rdata", got, 64'd0);
    do_op(1'b0, 3'b011, 64'h80000008, 64'h0, 5'd2, 0, got, wds);
    chk("ld_rdata", got, 64'h1122334455667788);

    do_op(1'b1, 3'b000, 64'h80000003, 64'hAB, 5'd3, 0, got, wds);
    chk("sb_wdata", wds, 64'h00000000AB000000);
    do_op(1'b0, 3'b000, 64'h80000003, 64'h0, 5'd4, 0, got, wds);
    chk("lb_rdata", got, 64'hFFFFFFFFFFFFFFAB);
    do_op(1'b0, 3'b100, 64'h80000003, 64'h0, 5'd5, 0, got, wds);
    chk("lbu_rdata", got, 64'h00000000000000AB);

    do_op(1'b1, 3'b010, 64'h80000004, 64'h80001234, 5'd6, 0, got, wds);
    do_op(1'b0, 3'b010, 64'h80000004, 64'h0, 5'd7, 0, got, wds);
    chk("lw_rdata", got, 64'hFFFFFFFF80001234);
    do_op(1'b0, 3'b110, 64'h80000004, 64'h0, 5'd8, 0, got, wds);
    chk("lwu_rdata", got, 64'h0000000080001234);

    do_op(1'b0, 3'b001, 64'h80000001, 64'h0, 5'd9, 0, got, wds);
    chk("lh_mis_rdata", got, 64'd0);
    do_op(1'b0, 3'b111, 64'h80000000, 64'h0, 5'd10, 0, got, wds);
    do_op(1'b1, 3'b100, 64'h80000010, 64'h55, 5'd11, 0, got, wds);

    do_op(1'b0, 3'b011, 64'h80000008, 64'h0, 5'd12, 5, got, wds);
    chk("bp_rdata", got, 64'h1122334455667788);

    // Reset in the middle of a store's access cycle
    in_valid = 1'b1; in_store = 1'b1; in_funct3 = 3'b011;
    in_addr = 64'h80000008; in_wdata = 64'hDEADBEEFCAFEF00D; in_tag = 5'd13;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("rstacc_ena_before", 64'(mem_ena), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstacc_ena", 64'(mem_ena), 64'd0);
    chk("rstacc_wen", 64'(mem_wen), 64'd0);
    chk("rstacc_valid", 64'(out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_out_rdata", out_rdata, 64'd0);
    chk("rel_out_tag", 64'(out_tag), 64'd0);
    chk("rel_out_store", 64'(out_store), 64'd0);
    chk("rel_out_misalign", 64'(out_misalign), 64'd0);
    chk("rel_mem_addr", mem_addr, 64'd0);
    chk("rel_mem_wdata", mem_wdata, 64'd0);
    @(negedge clk);
    do_op(1'b0, 3'b011, 64'h80000008, 64'h0, 5'd14, 0, got, wds);
    chk("rstacc_readback", got, 64'h1122334455667788);

    // Reset while a result is waiting in RESP
    model(1'b0, 3'b011, 64'h80000008, 64'h0, exp_mis_d, exp_rd_d);
    in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'b011; in_addr = 64'h80000008; in_tag = 5'd15;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstresp_valid_before", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstresp_valid", 64'(out_valid), 64'd0);
    chk("rstresp_rdata", out_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 64'h80000000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      do_op(st, f3, a, {$urandom(), $urandom()}, 5'($urandom()), $urandom_range(0, 2), got, wds);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
